// File: rtl/shader_dispatch.sv
// Shares a pool of shader units across one triangle stream: dispatches each accepted
// triangle to the lowest idle unit and returns colours in acceptance order with a tag.
module shader_dispatch #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned TAG_W     = 8
) (
    input  logic                                  clk,
    input  logic                                  sreset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [2:0][31:0]                      in_p1,
    input  logic [2:0][31:0]                      in_p2,
    input  logic [2:0][31:0]                      in_p3,
    input  logic [2:0][31:0]                      view_vector,
    output logic                                  su_sreset,
    output logic [NUM_UNITS-1:0]                  su_start,
    output logic [NUM_UNITS-1:0][2:0][31:0]       su_p1,
    output logic [NUM_UNITS-1:0][2:0][31:0]       su_p2,
    output logic [NUM_UNITS-1:0][2:0][31:0]       su_p3,
    output logic [2:0][31:0]                      su_view,
    input  logic [NUM_UNITS-1:0][3:0]             su_color,
    input  logic [NUM_UNITS-1:0]                  su_done,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [3:0]                            out_color,
    output logic [TAG_W-1:0]                      out_tag,
    output logic [$clog2(NUM_UNITS+1)-1:0]        busy_count
);

    localparam int unsigned CntW = $clog2(NUM_UNITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitLow,
        StRun,
        StHold
    } unit_state_e;

    unit_state_e      state_q [NUM_UNITS];
    logic [TAG_W-1:0] tag_q   [NUM_UNITS];
    logic [3:0]       color_q [NUM_UNITS];
    logic [TAG_W-1:0] in_seq_q;
    logic [TAG_W-1:0] out_seq_q;

    logic [NUM_UNITS-1:0] idle;
    logic [NUM_UNITS-1:0] hit;
    logic [NUM_UNITS-1:0] grant;
    logic                 found;
    logic                 accept;
    logic                 pop;

    assign su_sreset = sreset;
    assign su_view   = view_vector;
    assign in_ready  = !sreset && (|idle);
    assign accept    = in_valid && in_ready;
    assign out_valid = |hit;
    assign pop       = out_valid && out_ready;

    always_comb begin
        idle       = '0;
        hit        = '0;
        grant      = '0;
        found      = 1'b0;
        out_color  = '0;
        out_tag    = '0;
        busy_count = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            idle[u] = (state_q[u] == StIdle);
            hit[u]  = (state_q[u] == StHold) && (tag_q[u] == out_seq_q);
            if (idle[u] && !found) begin
                grant[u] = 1'b1;
                found    = 1'b1;
            end
            if (!idle[u]) begin
                busy_count = busy_count + CntW'(1);
            end
            // Tags of outstanding units are unique, so at most one hit bit is set.
            out_color = out_color | ({4{hit[u]}} & color_q[u]);
            out_tag   = out_tag | ({TAG_W{hit[u]}} & tag_q[u]);
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            su_start  <= '0;
            in_seq_q  <= '0;
            out_seq_q <= '0;
            for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                state_q[u] <= StIdle;
                tag_q[u]   <= '0;
                color_q[u] <= '0;
                su_p1[u]   <= '0;
                su_p2[u]   <= '0;
                su_p3[u]   <= '0;
            end
        end else begin
            su_start <= '0;
            if (accept) begin
                in_seq_q <= in_seq_q + TAG_W'(1);
            end
            if (pop) begin
                out_seq_q <= out_seq_q + TAG_W'(1);
            end
            for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                unique case (state_q[u])
                    StIdle: begin
                        if (accept && grant[u]) begin
                            state_q[u]  <= StLaunch;
                            su_start[u] <= 1'b1;
                            su_p1[u]    <= in_p1;
                            su_p2[u]    <= in_p2;
                            su_p3[u]    <= in_p3;
                            tag_q[u]    <= in_seq_q;
                        end
                    end
                    StLaunch: state_q[u] <= StWaitLow;
                    // done is still the previous result's level here; wait for it to drop
                    StWaitLow: begin
                        if (!su_done[u]) begin
                            state_q[u] <= StRun;
                        end
                    end
                    StRun: begin
                        if (su_done[u]) begin
                            state_q[u] <= StHold;
                            color_q[u] <= su_color[u];
                        end
                    end
                    StHold: begin
                        if (pop && hit[u]) begin
                            state_q[u] <= StIdle;
                        end
                    end
                    default: state_q[u] <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shader_dispatch.sv
// Bench for shader_dispatch with behavioural shader units and an in-order scoreboard.
module tb_shader_dispatch;

    localparam int N  = 4;
    localparam int TW = 3;

    logic                       clk;
    logic                       sreset;
    logic                       in_valid;
    logic                       in_ready;
    logic [2:0][31:0]           in_p1, in_p2, in_p3, view_vector;
    logic                       su_sreset;
    logic [N-1:0]               su_start;
    logic [N-1:0][2:0][31:0]    su_p1, su_p2, su_p3;
    logic [2:0][31:0]           su_view;
    logic [N-1:0][3:0]          su_color;
    logic [N-1:0]               su_done;
    logic                       out_valid;
    logic                       out_ready;
    logic [3:0]                 out_color;
    logic [TW-1:0]              out_tag;
    logic [2:0]                 busy_count;

    shader_dispatch #(.NUM_UNITS(N), .TAG_W(TW)) dut (
        .clk        (clk),
        .sreset     (sreset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .view_vector(view_vector),
        .su_sreset  (su_sreset),
        .su_start   (su_start),
        .su_p1      (su_p1),
        .su_p2      (su_p2),
        .su_p3      (su_p3),
        .su_view    (su_view),
        .su_color   (su_color),
        .su_done    (su_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_color  (out_color),
        .out_tag    (out_tag),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_pop    = 0;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] shade(input logic [2:0][31:0] a, input logic [2:0][31:0] b,
                                         input logic [2:0][31:0] c);
        return a[0][3:0] ^ b[1][3:0] ^ c[2][3:0] ^ b[0][30:27] ^ 4'h1;
    endfunction

    // Behavioural units: done drops after start (odd units one cycle late), rises after lat.
    int         lat [N];
    int         cnt [N];
    logic [N-1:0] lowpend;
    always @(posedge clk) begin
        for (int u = 0; u < N; u++) begin
            if (sreset) begin
                su_done[u] <= 1'b1;
                lowpend[u] <= 1'b0;
                cnt[u]     <= 0;
            end else if (su_start[u]) begin
                cnt[u] <= lat[u];
                if (u % 2 == 1) lowpend[u] <= 1'b1;
                else            su_done[u] <= 1'b0;
            end else if (lowpend[u]) begin
                lowpend[u] <= 1'b0;
                su_done[u] <= 1'b0;
            end else if (!su_done[u]) begin
                if (cnt[u] == 0) begin
                    su_done[u]  <= 1'b1;
                    su_color[u] <= shade(su_p1[u], su_p2[u], su_p3[u]);
                end else begin
                    cnt[u] <= cnt[u] - 1;
                end
            end
        end
    end

    typedef struct {
        logic [TW-1:0] tag;
        logic [3:0]    color;
    } exp_t;
    exp_t          sb[$];
    logic [TW-1:0] exp_seq = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!sreset) begin
            if (in_valid && in_ready) begin
                sb.push_back('{exp_seq, shade(in_p1, in_p2, in_p3)});
                exp_seq = exp_seq + 1'b1;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    check_eq("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("out_tag", 32'(out_tag), 32'(e.tag));
                    check_eq("out_color", 32'(out_color), 32'(e.color));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_tri();
        for (int j = 0; j < 3; j++) begin
            in_p1[j] = $urandom;
            in_p2[j] = $urandom;
            in_p3[j] = $urandom;
        end
    endtask

    task automatic offer();
        bit ok = 1'b0;
        rand_tri();
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("offer_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 3000; k++) begin
            if (sb.size() == 0 && busy_count == 0) break;
            step(1);
        end
        check_eq("drain_queue", 32'(sb.size()), 32'd0);
        check_eq("drain_busy", 32'(busy_count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        bit          rose;
        int          acc0, pop0;

        sreset    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_p1 = '0; in_p2 = '0; in_p3 = '0;
        view_vector = '0;
        view_vector[2] = 32'h3f80_0000;
        for (int u = 0; u < N; u++) lat[u] = 3;

        // Reset state
        step(3);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_su_sreset", 32'(su_sreset), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy_count), 32'd0);
        check_eq("rst_su_start", 32'(su_start), 32'd0);
        @(posedge clk); #1;
        sreset = 1'b0;
        @(negedge clk);
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_su_sreset", 32'(su_sreset), 32'd0);
        check_eq("su_view", su_view[2], 32'h3f80_0000);
        check_eq("rst_su_p1", su_p1[0][0], 32'd0);
        @(posedge clk); #1;

        // Single triangle, latency profile
        out_ready = 1'b1;
        lat[0] = 6;
        in_p1 = '0; in_p2 = '0; in_p3 = '0;
        in_p2[0] = 32'h3f80_0000;
        in_p3[1] = 32'h3f80_0000;
        in_p1[0] = 32'h0000_0005;
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("single_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("single_start", 32'(su_start), 32'b0001);
        check_eq("single_busy", 32'(busy_count), 32'd1);
        @(negedge clk);
        check_eq("single_start_end", 32'(su_start), 32'd0);
        rose = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (su_done[0]) begin
                rose = 1'b1;
                break;
            end
        end
        check_eq("single_done_rose", 32'(rose), 32'd1);
        check_eq("single_valid_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("single_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check_eq("single_busy_after", 32'(busy_count), 32'd0);
        check_eq("single_hold_p1", su_p1[0][0], 32'h0000_0005);
        @(posedge clk); #1;

        // Back-to-back fill with downstream stalled
        out_ready = 1'b0;
        lat[0] = 40; lat[1] = 10; lat[2] = 25; lat[3] = 5;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 5);
            rand_tri();
            @(negedge clk);
            check_eq("b2b_ready", 32'(in_ready), 32'(i < 4));
            check_eq("b2b_start", 32'(su_start), (i == 0 || i > 4) ? 32'd0 : 32'd1 << (i - 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("full_busy", 32'(busy_count), 32'd4);
        step(60);
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_tag", 32'(out_tag), 32'(sb[0].tag));
        check_eq("stall_color", 32'(out_color), 32'(sb[0].color));
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check_eq("one_pop", 32'(sb.size()), 32'd3);
        step(2);
        check_eq("stall2_queue", 32'(sb.size()), 32'd3);
        check_eq("stall2_valid", 32'(out_valid), 32'd1);
        check_eq("stall2_tag", 32'(out_tag), 32'(sb[0].tag));
        check_eq("stall2_color", 32'(out_color), 32'(sb[0].color));
        out_ready = 1'b1;
        drain();

        // Out-of-order completion, in-order return
        for (int i = 0; i < 4; i++) offer();
        step(25);
        check_eq("ooo_no_valid", 32'(out_valid), 32'd0);
        check_eq("ooo_busy", 32'(busy_count), 32'd4);
        check_eq("ooo_queue", 32'(sb.size()), 32'd4);
        drain();

        // Reset while units are running
        for (int u = 0; u < N; u++) lat[u] = 50;
        for (int i = 0; i < 3; i++) offer();
        step(5);
        out_ready = 1'b0;
        sreset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_su_sreset", 32'(su_sreset), 32'd1);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_count), 32'd0);
        check_eq("mid_rst_start", 32'(su_start), 32'd0);
        check_eq("mid_rst_p1", su_p1[0][1], 32'd0);
        sb.delete();
        exp_seq = '0;
        @(posedge clk); #1;
        sreset = 1'b0;
        out_ready = 1'b1;
        lat[0] = 4;
        offer();
        @(negedge clk);
        check_eq("post_rst_unit0", 32'(su_start), 32'b0001);
        check_eq("post_rst_tag", 32'(sb[0].tag), 32'd0);
        @(posedge clk); #1;
        drain();

        // Stream with random latencies and random backpressure across tag wrap
        acc0 = n_acc;
        pop0 = n_pop;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    for (int u = 0; u < N; u++) lat[u] = $urandom_range(1, 30);
                    if ($urandom_range(0, 2) == 0) step(1);
                    offer();
                end
            end
            begin
                for (int k = 0; k < 400; k++) begin
                    step(1);
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check_eq("stream_accepts", 32'(n_acc - acc0), 32'd20);
        check_eq("stream_pops", 32'(n_pop - pop0), 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shader_dispatch.md
Name: shader_dispatch

Overview:
- Scheduler that shares a pool of NUM_UNITS shader_unit instances among a single stream of triangles.
- Accepts triangles (three NDC vertices) over a valid/ready handshake and assigns each to an idle unit. Holds the vertex operands stable for that unit's whole computation, and sequences the unit's start/done protocol.
- Returns the 4-bit colors in acceptance order, each tagged with a sequence number. Sits between the triangle setup stage and the rasterizer colour input.

Parameters:
- NUM_UNITS, 4, number of shader_unit instances managed (1..8).
- TAG_W, 8, sequence-tag width; must satisfy 2**TAG_W >= 2*NUM_UNITS.

Ports:
- clk  in  1  clock.
- sreset  in  1  synchronous active-high reset.
- in_valid  in  1  triangle offered.
- in_ready  out  1  triangle accepted this cycle when in_valid && in_ready.
- in_p1, in_p2, in_p3  in  32 x[3] each  vertex coordinates, IEEE-754 single.
- view_vector  in  32 x[3]  shared view vector; passed straight to all units and held stable by the upstream block.
- su_sreset  out  1  reset to every unit; equals sreset combinationally.
- su_start  out  NUM_UNITS  per-unit start pulse.
- su_p1, su_p2, su_p3  out  32 x[NUM_UNITS][3] each  per-unit held vertex operands.
- su_view  out  32 x[3]  copy of view_vector.
- su_color  in  4 x[NUM_UNITS]  unit colour; valid while su_done is high.
- su_done  in  NUM_UNITS  unit done level; high in the unit's idle/result state.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes when out_valid && out_ready.
- out_color  out  4  colour of the oldest outstanding triangle.
- out_tag  out  TAG_W  sequence number of that triangle.
- busy_count  out  clog2(NUM_UNITS+1)  number of units not IDLE.

Behaviour:
- Per-unit FSM with states IDLE, LAUNCH, WAIT_LOW, RUN, HOLD.
  - IDLE -> LAUNCH on accept. On that accept: load su_p1/2/3[u] from in_p*, and store tag[u] = in_seq.
  - LAUNCH: su_start[u] = 1 for exactly this one cycle -> WAIT_LOW.
  - WAIT_LOW: su_done[u] is still high in the cycle after start, so it is ignored here. Transition to RUN on su_done[u] == 0.
  - RUN -> HOLD on su_done[u] == 1. In the same cycle, latch color_r[u] = su_color[u].
  - HOLD -> IDLE on the cycle the result is popped.
- Operand hold: su_p*[u] changes only on an accept to unit u; it is stable through LAUNCH..HOLD.
- Dispatch: in_ready = !sreset && (any unit IDLE). The lowest-index IDLE unit is chosen. One accept per cycle maximum.
- Sequencing:
  - in_seq increments on each accept.
  - out_seq increments on each pop.
  - Both wrap modulo 2**TAG_W.
- Output:
  - out_valid = 1 iff some unit u is in HOLD with tag[u] == out_seq.
  - out_color = color_r[u] and out_tag = tag[u] for that unit.
  - When out_valid is 0, out_color and out_tag are 0.
  - Results are emitted strictly in acceptance order even if units finish out of order. A finished unit stays in HOLD, unavailable for dispatch, until it is popped.
- Latency with one idle unit and out_ready = 1:
  - accept at cycle 0, su_start at cycle 1, unit done low at cycle 2.
  - out_valid is asserted 1 cycle after su_done rises.
- Simultaneous pop and accept: the unit freed by the pop becomes IDLE only on the next cycle, so it is not eligible in the pop cycle.
- Full: all units non-IDLE -> in_ready = 0, and in_valid is ignored.
- Empty: no HOLD unit matching out_seq -> out_valid = 0.
- Backpressure: out_valid is held with stable out_color and out_tag until out_ready.
- Reset (sreset = 1, at any time including mid-computation), effective next edge:
  - all units IDLE, su_start = 0, in_seq = out_seq = 0, color_r = 0, tag = 0, su_p* = 0.
  - out_valid = 0, busy_count = 0, in_ready = 0 while sreset is high.
  - Units are reset via su_sreset; in-flight triangles are discarded and no output is produced for them.
- An su_done glitch in IDLE or HOLD is ignored.

Test Plan:
- Single triangle p1 = (0,0,0), p2 = (1,0,0), p3 = (0,1,0), view = (0,0,1), real shader_unit -> su_start[0] pulses 1 cycle after accept; out_color = 4'd8 (int(8*(1-1)+...) per unit) and out_tag = 0; busy_count returns to 0 after pop.
- Offer 5 triangles back to back with NUM_UNITS = 4 and out_ready = 0 -> units 0..3 launched on consecutive cycles; in_ready = 0 at the 5th; busy_count = 4.
- Behavioural units with latencies 40/10/25/5 cycles, out_ready = 1 -> outputs emitted with tags 0, 1, 2, 3 in order; unit 3 holds in HOLD until tags 0..2 are popped.
- out_ready toggled 1-0-1 while out_valid -> out_color and out_tag are stable across the stall; exactly one pop per high cycle.
- sreset asserted while 3 units are in RUN -> next cycle out_valid = 0, busy_count = 0, su_sreset = 1; the next triangle gets tag 0 on unit 0.
- TAG_W = 3, NUM_UNITS = 2, 20 triangles streamed -> tags 0..7 repeat, ordering preserved across the wrap, no lost or duplicated results.
